encrypt_pipe_class_stage: RTL and testbench

//  Multi-lane data-compare stage at the head of the encrypt shift pipe. Classifies LANES ASCII bytes per beat
//  (upper/lower alpha, optional digit) and emits a per-lane ALPHA_N-bit one-hot index for single-cycle rotation.

---
 rtl/encrypt_pipe_class_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_encrypt_pipe_class_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_pipe_class_stage.sv
// Purpose : classify ASCII lanes (upper/lower/digit), build per-lane one-hot alphabet index, forward sideband.
// Latency : 1 cycle from accept to output; every output field is registered at the skid-buffer head.
// Backpr. : 2-entry skid buffer; in_ready (registered) drops only while both entries are full.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; din carries LANES bytes, lane i = din[8i+7:8i]
//   lane_en               per-lane enable (disabled lanes produce zero flags and zero one-hot)
//   k1,k2,k3,rot_freq,shift_en,shift_amt,mode   sideband, forwarded unchanged with the beat
//   cnt_clr               synchronous clear of alpha_cnt
//   out_valid/out_ready   output handshake
//   is_upper/is_lower/is_digit, onehot_data     per-lane classification of the head beat
//   k1_o..mode_o          forwarded sideband of the head beat
//   alpha_cnt             saturating count of alpha lanes accepted
module encrypt_pipe_class_stage #(
  parameter int LANES    = 4,
  parameter int ALPHA_N  = 26,
  parameter bit DIGIT_EN = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*8-1:0]         din,
  input  logic [LANES-1:0]           lane_en,
  input  logic [7:0]                 k1,
  input  logic [7:0]                 k2,
  input  logic [7:0]                 k3,
  input  logic [2:0]                 rot_freq,
  input  logic                       shift_en,
  input  logic                       shift_amt,
  input  logic                       mode,
  input  logic                       cnt_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           is_upper,
  output logic [LANES-1:0]           is_lower,
  output logic [LANES-1:0]           is_digit,
  output logic [LANES*ALPHA_N-1:0]   onehot_data,
  output logic [7:0]                 k1_o,
  output logic [7:0]                 k2_o,
  output logic [7:0]                 k3_o,
  output logic [2:0]                 rot_freq_o,
  output logic                       shift_en_o,
  output logic                       shift_amt_o,
  output logic                       mode_o,
  output logic [CNT_W-1:0]           alpha_cnt
);

  // One buffered beat: classification results plus the sideband that travels with it.
  typedef struct packed {
    logic [LANES-1:0]         upper;
    logic [LANES-1:0]         lower;
    logic [LANES-1:0]         digit;
    logic [LANES*ALPHA_N-1:0] onehot;
    logic [7:0]               k1;
    logic [7:0]               k2;
    logic [7:0]               k3;
    logic [2:0]               rot_freq;
    logic                     shift_en;
    logic                     shift_amt;
    logic                     mode;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  beat_t             head_q, head_d;
  beat_t             tail_q, tail_d;
  beat_t             new_beat;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  new_pop;
  logic [7:0]        lane_byte;
  logic [ALPHA_N-1:0] lane_oh;

  logic accept;
  logic deliver;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Lane classification of the incoming beat (used only on accept)
  // ---------------------------------------------------------------------------
  always_comb begin
    new_beat  = '0;
    lane_byte = '0;
    lane_oh   = '0;
    new_pop   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_byte = din[8*i +: 8];
      lane_oh   = '0;
      if (mode && lane_en[i]) begin
        // Default for any enabled lane that is not alpha: pass the byte through.
        lane_oh = {{(ALPHA_N-8){1'b0}}, lane_byte};
        if (shift_en) begin
          if (lane_byte >= 8'd65 && lane_byte <= 8'd90) begin
            new_beat.upper[i] = 1'b1;
            lane_oh = {{(ALPHA_N-1){1'b0}}, 1'b1} << (lane_byte - 8'd65);
          end else if (lane_byte >= 8'd97 && lane_byte <= 8'd122) begin
            new_beat.lower[i] = 1'b1;
            lane_oh = {{(ALPHA_N-1){1'b0}}, 1'b1} << (lane_byte - 8'd97);
          end else if (DIGIT_EN && lane_byte >= 8'd48 && lane_byte <= 8'd57) begin
            new_beat.digit[i] = 1'b1;
          end
        end
      end
      new_beat.onehot[i*ALPHA_N +: ALPHA_N] = lane_oh;
      new_pop = new_pop + CNT_W'(new_beat.upper[i] | new_beat.lower[i]);
    end
    new_beat.k1        = k1;
    new_beat.k2        = k2;
    new_beat.k3        = k3;
    new_beat.rot_freq  = rot_freq;
    new_beat.shift_en  = shift_en;
    new_beat.shift_amt = shift_amt;
    new_beat.mode      = mode;
  end

  // ---------------------------------------------------------------------------
  // Skid buffer control: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Registered ready: low exactly while the next state is full.
      in_ready_q <= (state_d != S_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !deliver)      state_d = S_TWO;
        else if (deliver && !accept) state_d = S_EMPTY;
      end
      S_TWO:   if (deliver) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    in_ready  = in_ready_q;
  end

  // ---------------------------------------------------------------------------
  // Buffer datapath: head feeds the outputs, tail holds the skid entry
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      S_EMPTY: if (accept) head_d = new_beat;
      S_ONE: begin
        // Simultaneous accept and deliver replaces the head directly.
        if (accept && deliver) head_d = new_beat;
        else if (accept)       tail_d = new_beat;
      end
      S_TWO:   if (deliver) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating alpha counter; a clear in the same cycle as an accept keeps
  // the new beat's contribution.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_base = cnt_clr ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + {1'b0, new_pop};
    cnt_d    = cnt_base;
    if (accept) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign is_upper    = head_q.upper;
  assign is_lower    = head_q.lower;
  assign is_digit    = head_q.digit;
  assign onehot_data = head_q.onehot;
  assign k1_o        = head_q.k1;
  assign k2_o        = head_q.k2;
  assign k3_o        = head_q.k3;
  assign rot_freq_o  = head_q.rot_freq;
  assign shift_en_o  = head_q.shift_en;
  assign shift_amt_o = head_q.shift_amt;
  assign mode_o      = head_q.mode;
  assign alpha_cnt   = cnt_q;

endmodule

// File: tb/tb_encrypt_pipe_class_stage.sv
// Bench for encrypt_pipe_class_stage: reference queue model plus hand-computed literal checks.
module tb_encrypt_pipe_class_stage;

  localparam int LANES = 4;
  localparam int AN    = 26;
  localparam int W     = LANES * AN;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [31:0]     din;
  logic [3:0]      lane_en;
  logic [7:0]      k1, k2, k3;
  logic [2:0]      rot_freq;
  logic            shift_en, shift_amt, mode, cnt_clr;
  logic            out_valid, out_ready;
  logic [3:0]      is_upper, is_lower, is_digit;
  logic [W-1:0]    onehot_data;
  logic [7:0]      k1_o, k2_o, k3_o;
  logic [2:0]      rot_freq_o;
  logic            shift_en_o, shift_amt_o, mode_o;
  logic [15:0]     alpha_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encrypt_pipe_class_stage #(.LANES(4), .ALPHA_N(26), .DIGIT_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .lane_en(lane_en),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq),
    .shift_en(shift_en), .shift_amt(shift_amt), .mode(mode), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .is_upper(is_upper), .is_lower(is_lower), .is_digit(is_digit),
    .onehot_data(onehot_data),
    .k1_o(k1_o), .k2_o(k2_o), .k3_o(k3_o), .rot_freq_o(rot_freq_o),
    .shift_en_o(shift_en_o), .shift_amt_o(shift_amt_o), .mode_o(mode_o),
    .alpha_cnt(alpha_cnt)
  );

  typedef struct {
    logic [3:0]   up;
    logic [3:0]   lo;
    logic [3:0]   dg;
    logic [W-1:0] oh;
    logic [7:0]   k1, k2, k3;
    logic [2:0]   rot;
    logic         se, sa, md;
  } exp_t;

  exp_t q[$];
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  // What a beat must look like on the output, straight from the lane rules.
  function automatic exp_t model(input logic [31:0] d, input logic [3:0] en,
                                 input logic md, input logic se);
    exp_t e;
    e.up = '0; e.lo = '0; e.dg = '0; e.oh = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [7:0]    c;
      logic [AN-1:0] v;
      c = d[8*i +: 8];
      v = '0;
      if (md && en[i]) begin
        if (!se) v = AN'(c);
        else if (c >= "A" && c <= "Z") begin e.up[i] = 1'b1; v = AN'(1) << (c - "A"); end
        else if (c >= "a" && c <= "z") begin e.lo[i] = 1'b1; v = AN'(1) << (c - "a"); end
        else if (c >= "0" && c <= "9") begin e.dg[i] = 1'b1; v = AN'(c); end
        else v = AN'(c);
      end
      e.oh[i*AN +: AN] = v;
    end
    e.k1 = k1; e.k2 = k2; e.k3 = k3; e.rot = rot_freq;
    e.se = se; e.sa = shift_amt; e.md = md;
    return e;
  endfunction

  // Reference: FIFO of at most two beats, plus a saturating counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      bit   acc, dlv;
      exp_t e;
      acc = in_valid && (q.size() < 2);
      dlv = (q.size() > 0) && out_ready;
      if (cnt_clr) exp_cnt = 0;
      if (acc) begin
        e = model(din, lane_en, mode, shift_en);
        exp_cnt = exp_cnt + $countones(e.up | e.lo);
        if (exp_cnt > 65535) exp_cnt = 65535;
      end
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, (q.size() < 2));
      chk("out_valid", out_valid, (q.size() > 0));
      chk("alpha_cnt", alpha_cnt, exp_cnt[15:0]);
      if (q.size() > 0) begin
        chk("flags", {is_upper, is_lower, is_digit}, {q[0].up, q[0].lo, q[0].dg});
        chk("onehot", onehot_data, q[0].oh);
        chk("sideband", {k1_o, k2_o, k3_o, rot_freq_o, shift_en_o, shift_amt_o, mode_o},
            {q[0].k1, q[0].k2, q[0].k3, q[0].rot, q[0].se, q[0].sa, q[0].md});
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [31:0] d, input logic [3:0] en, input logic md,
                      input logic se, input logic clr);
    bit got;
    din = d; lane_en = en; mode = md; shift_en = se; cnt_clr = clr; in_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_data"}, {is_upper, is_lower, is_digit, onehot_data}, '0);
    chk({tag, "_side"}, {k1_o, k2_o, k3_o, rot_freq_o, shift_en_o, shift_amt_o, mode_o}, '0);
    chk({tag, "_cnt"}, alpha_cnt, 16'd0);
  endtask

  logic [W-1:0] oh_exp;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; din = '0; lane_en = '0;
    k1 = 8'h11; k2 = 8'h22; k3 = 8'h33; rot_freq = 3'd5;
    shift_en = 1'b0; shift_amt = 1'b1; mode = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // 1: "AZaz" classification and one-hot top-of-alphabet bits
    send(pk("A", "Z", "a", "z"), 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_upper", is_upper, 4'b0011);
    chk("t1_lower", is_lower, 4'b1100);
    oh_exp = {26'd1 << 25, 26'd1, 26'd1 << 25, 26'd1};
    chk("t1_onehot", onehot_data, oh_exp);
    chk("t1_cnt", alpha_cnt, 16'd4);
    @(posedge clk); #1;

    // 2: boundary bytes are non-alpha
    k1 = 8'hA5; k2 = 8'h5A; k3 = 8'hC3; rot_freq = 3'd2; shift_amt = 1'b0;
    send(pk("@", "[", 8'h60, "{"), 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_flags", {is_upper, is_lower, is_digit}, 12'h000);
    oh_exp = {26'd123, 26'd96, 26'd91, 26'd64};
    chk("t2_onehot", onehot_data, oh_exp);
    chk("t2_cnt", alpha_cnt, 16'd4);
    @(posedge clk); #1;

    // 3: digits, then mode=0, then shift_en=0 and a partial lane_en
    send(pk("0", "9", "a", "!"), 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_digit", is_digit, 4'b0011);
    chk("t3_lower", is_lower, 4'b0100);
    chk("t3_lane2", onehot_data[2*AN +: AN], 26'd1);
    chk("t3_lane3", onehot_data[3*AN +: AN], 26'd33);
    @(posedge clk); #1;
    send(pk("0", "9", "a", "!"), 4'hF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_m0", {is_upper, is_lower, is_digit, onehot_data}, '0);
    @(posedge clk); #1;
    send(pk("Q", "q", "5", "~"), 4'hF, 1'b1, 1'b0, 1'b0);
    send(pk("Q", "q", "5", "~"), 4'b1010, 1'b1, 1'b1, 1'b0);
    idle(2);

    // 4: backpressure, skid buffer fill and ordered drain
    out_ready = 1'b0;
    k1 = 8'h01; send(pk("B", "b", "1", "."), 4'hF, 1'b1, 1'b1, 1'b0);
    k1 = 8'h02; send(pk("C", "c", "2", ","), 4'hF, 1'b1, 1'b1, 1'b0);
    k1 = 8'h03; din = pk("D", "d", "3", ";"); in_valid = 1'b1;
    @(negedge clk);
    chk("t4_full_ready", in_ready, 1'b0);
    chk("t4_full_valid", out_valid, 1'b1);
    chk("t4_head_k1", k1_o, 8'h01);
    idle(3);
    out_ready = 1'b1;
    send(pk("D", "d", "3", ";"), 4'hF, 1'b1, 1'b1, 1'b0);
    k1 = 8'h04; send(pk("E", "e", "4", ":"), 4'hF, 1'b1, 1'b1, 1'b0);
    k1 = 8'h05; send(pk("F", "f", "5", "?"), 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_last_k1", k1_o, 8'h05);
    idle(3);
    @(negedge clk);
    chk("t4_drained", out_valid, 1'b0);
    @(posedge clk); #1;

    // 5: clear, preload to 0xFFFE, saturate, clear with accept
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr", alpha_cnt, 16'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16383; i++) send(pk("A", "A", "A", "A"), 4'hF, 1'b1, 1'b1, 1'b0);
    send(pk("A", "A", "A", "A"), 4'b0011, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_preload", alpha_cnt, 16'hFFFE);
    @(posedge clk); #1;
    send(pk("A", "A", "A", "A"), 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_sat", alpha_cnt, 16'hFFFF);
    @(posedge clk); #1;
    send(pk("A", "A", "A", "A"), 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_hold", alpha_cnt, 16'hFFFF);
    @(posedge clk); #1;
    send(pk("A", "b", "!", "!"), 4'hF, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_clr_acc", alpha_cnt, 16'd2);
    @(posedge clk); #1;

    // 6: async reset with the buffer full
    out_ready = 1'b0;
    send(pk("G", "g", "7", "#"), 4'hF, 1'b1, 1'b1, 1'b0);
    send(pk("H", "h", "8", "$"), 4'hF, 1'b1, 1'b1, 1'b0);
    #1;
    chk("t6_pre_full", in_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(pk("I", "i", "9", "%"), 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_recover_cnt", alpha_cnt, 16'd2);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
